// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock-divider channels.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package clkdiv_pkg;

  // Internal counter/config width; the top-level CNT_W must not exceed it.
  localparam int CLKDIV_CNT_W = 28;
  localparam int CLKDIV_DEFAULT_DIV = 100000000;
  localparam int MIN_DIV = 2;

  typedef logic [CLKDIV_CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t div;
    cnt_t high;
  } clkdiv_cfg_t;

  // Force a config into the legal range: period of at least MIN_DIV cycles, high phase no longer than the period.
  function automatic clkdiv_cfg_t clamp_cfg(input clkdiv_cfg_t cfg);
    clkdiv_cfg_t c;
    c = cfg;
    if (c.div < cnt_t'(MIN_DIV)) c.div = cnt_t'(MIN_DIV);
    if (c.high > c.div) c.high = c.div;
    return c;
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Config/load bus and divided outputs of the multi-channel clock divider.
// Latency: n/a (wiring only).
// Backpressure: none; load_valid is a fire-and-forget strobe and outputs are free-running levels/pulses.
interface multi_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_enable;
  logic              load_valid;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_div;
  logic [CNT_W-1:0]  load_high;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] load_pending;

  modport master (
    output ch_enable, load_valid, load_ch, load_div, load_high,
    input  clock_out, tick, load_pending
  );

  modport slave (
    input  ch_enable, load_valid, load_ch, load_div, load_high,
    output clock_out, tick, load_pending
  );

endinterface

// File: rtl/clkdiv_channel.sv
// One programmable divider: counter, active + shadow config, pending flag, registered clock_out/tick.
// Latency: clock_out/tick follow the counter value by 1 cycle; a shadow config lands at the next period wrap.
// Backpressure: none; a write is always accepted and a later write simply replaces an unapplied one.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sync_req,
  input  logic        wr_vld,
  input  clkdiv_cfg_t wr_cfg,
  output logic        clock_out,
  output logic        tick,
  output logic        load_pending
);

  localparam clkdiv_cfg_t RESET_CFG = clamp_cfg({cnt_t'(DEFAULT_DIV), cnt_t'(DEFAULT_DIV / 2)});

  cnt_t        cnt;
  clkdiv_cfg_t active_cfg;
  clkdiv_cfg_t shadow_cfg;
  logic        wrap;
  logic        apply;
  clkdiv_cfg_t next_cfg;

  // Period boundary detection and the config that the next period will run with.
  always_comb begin
    wrap     = (cnt >= (active_cfg.div - cnt_t'(1)));
    apply    = load_pending && (!enable || wrap || sync_req);
    next_cfg = apply ? clamp_cfg(shadow_cfg) : active_cfg;
  end

  // Counter, config hand-over and registered outputs; the running period always finishes on its old config.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      active_cfg   <= RESET_CFG;
      shadow_cfg   <= RESET_CFG;
      load_pending <= 1'b0;
      clock_out    <= 1'b0;
      tick         <= 1'b0;
    end else begin
      if (apply) active_cfg <= next_cfg;

      // A write landing on the apply edge goes to the shadow only and keeps pending set.
      if (wr_vld) begin
        shadow_cfg   <= wr_cfg;
        load_pending <= 1'b1;
      end else if (apply) begin
        load_pending <= 1'b0;
      end

      if (!enable) begin
        cnt       <= '0;
        clock_out <= 1'b0;
        tick      <= 1'b0;
      end else if (sync_req) begin
        cnt       <= '0;
        clock_out <= (next_cfg.high != '0);
        tick      <= 1'b0;
      end else begin
        cnt       <= wrap ? '0 : cnt + cnt_t'(1);
        clock_out <= (cnt < active_cfg.high);
        tick      <= (cnt == (active_cfg.div - cnt_t'(1)));
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent glitch-free programmable clock-enable dividers sharing clock_in; optional CLKDIV_PHASE_SYNC_EN adds sync_req.
// Latency: outputs registered, 1 cycle behind each channel counter; config loads apply at the channel's next period wrap.
// Backpressure: none; load strobes are always accepted, writes to channels >= NUM_CH are dropped.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  multi_clock_divider_if.slave bus
`ifdef CLKDIV_PHASE_SYNC_EN
  ,
  input  logic                 sync_req
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic        sync_all;
  clkdiv_cfg_t load_cfg;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync_all = sync_req;
`else
  assign sync_all = 1'b0;
`endif

  // Load payload widened/narrowed to the internal config width (CNT_W is expected to be <= CLKDIV_CNT_W).
  assign load_cfg = '{div: cnt_t'(bus.load_div), high: cnt_t'(bus.load_high)};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_vld;

    // Channel select; indices with no channel never match, so those writes vanish.
    assign wr_vld = bus.load_valid && (bus.load_ch == CH_W'(i));

    clkdiv_channel #(
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in     (clock_in),
      .reset_n      (reset_n),
      .enable       (bus.ch_enable[i]),
      .sync_req     (sync_all),
      .wr_vld       (wr_vld),
      .wr_cfg       (load_cfg),
      .clock_out    (bus.clock_out[i]),
      .tick         (bus.tick[i]),
      .load_pending (bus.load_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (3 channels, reset divisor 10).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_multi_clock_divider;

  logic clk;
  logic rst_n;
  logic sync_req;
  int   checks;
  int   errors;

  multi_clock_divider_if #(.NUM_CH(3), .CNT_W(28)) bus ();

  multi_clock_divider #(
    .NUM_CH      (3),
    .CNT_W       (28),
    .DEFAULT_DIV (10)
  ) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (bus)
`ifdef CLKDIV_PHASE_SYNC_EN
    ,
    .sync_req (sync_req)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int ch, input int div, input int high);
    bus.load_valid = 1'b1;
    bus.load_ch    = 2'(ch);
    bus.load_div   = 28'(div);
    bus.load_high  = 28'(high);
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    sync_req       = 1'b0;
    checks         = 0;
    errors         = 0;
    bus.ch_enable  = '0;
    // Load strobe held during reset must be ignored (otherwise ch0 would run 3/1).
    load(0, 3, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clock_out", 32'(bus.clock_out), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_pending", 32'(bus.load_pending), 0);
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_load_ignored", 32'(bus.load_pending), 0);

    // Test 1: ch0 on reset config 10/5.
    bus.ch_enable[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t1_out k=%0d", k), 32'(bus.clock_out[0]), 32'(((k - 1) % 10) < 5));
      chk($sformatf("t1_tick k=%0d", k), 32'(bus.tick[0]), 32'((k % 10) == 0));
    end

    // Test 2: ch1 8/4, reload 6/2 mid-period.
    load(1, 8, 4);
    step();
    chk("t2_pend_set", 32'(bus.load_pending[1]), 1);
    bus.load_valid = 1'b0;
    step();
    chk("t2_pend_apply_dis", 32'(bus.load_pending[1]), 0);
    bus.ch_enable[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k <= 8) begin
        chk($sformatf("t2_out k=%0d", k), 32'(bus.clock_out[1]), 32'(((k - 1) % 8) < 4));
        chk($sformatf("t2_tick k=%0d", k), 32'(bus.tick[1]), 32'(k == 8));
      end else begin
        chk($sformatf("t2_out k=%0d", k), 32'(bus.clock_out[1]), 32'(((k - 9) % 6) < 2));
        chk($sformatf("t2_tick k=%0d", k), 32'(bus.tick[1]), 32'(((k - 9) % 6) == 5));
      end
      chk($sformatf("t2_pend k=%0d", k), 32'(bus.load_pending[1]), 32'(k >= 4 && k <= 7));
      if (k == 3) load(1, 6, 2);
      if (k == 4) bus.load_valid = 1'b0;
    end

    // Out-of-range channel index is dropped.
    load(3, 7, 3);
    step();
    bus.load_valid = 1'b0;
    chk("oor_pending", 32'(bus.load_pending), 0);

    // Test 3: ch2 clamping 0/5 -> 2/2, then high=0.
    load(2, 0, 5);
    step();
    bus.load_valid = 1'b0;
    step();
    bus.ch_enable[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("t3_out k=%0d", k), 32'(bus.clock_out[2]), 32'(k <= 8));
      chk($sformatf("t3_tick k=%0d", k), 32'(bus.tick[2]), 32'((k % 2) == 0));
      if (k == 7) chk("t3_pend_set", 32'(bus.load_pending[2]), 1);
      if (k == 8) chk("t3_pend_clr", 32'(bus.load_pending[2]), 0);
      if (k == 6) load(2, 2, 0);
      if (k == 7) bus.load_valid = 1'b0;
    end

    // Test 4: ch2 4/2, load 6/3 on the wrap edge, overwrite with 5/1 before the next wrap.
    bus.ch_enable[2] = 1'b0;
    step();
    load(2, 4, 2);
    step();
    bus.load_valid = 1'b0;
    step();
    bus.ch_enable[2] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k <= 8) begin
        chk($sformatf("t4_out k=%0d", k), 32'(bus.clock_out[2]), 32'(((k - 1) % 4) < 2));
        chk($sformatf("t4_tick k=%0d", k), 32'(bus.tick[2]), 32'((k % 4) == 0));
      end else begin
        chk($sformatf("t4_out k=%0d", k), 32'(bus.clock_out[2]), 32'(((k - 9) % 5) < 1));
        chk($sformatf("t4_tick k=%0d", k), 32'(bus.tick[2]), 32'(((k - 9) % 5) == 4));
      end
      chk($sformatf("t4_pend k=%0d", k), 32'(bus.load_pending[2]), 32'(k >= 4 && k <= 7));
      if (k == 3) load(2, 6, 3);
      if (k == 4) bus.load_valid = 1'b0;
      if (k == 5) load(2, 5, 1);
      if (k == 6) bus.load_valid = 1'b0;
    end

    // Test 5: ch0 load 4/3, drop enable, re-enable.
    load(0, 4, 3);
    step();
    chk("t5_pend_set", 32'(bus.load_pending[0]), 1);
    bus.load_valid   = 1'b0;
    bus.ch_enable[0] = 1'b0;
    step();
    chk("t5_dis_out", 32'(bus.clock_out[0]), 0);
    chk("t5_dis_tick", 32'(bus.tick[0]), 0);
    chk("t5_dis_pend", 32'(bus.load_pending[0]), 0);
    step();
    chk("t5_dis_out2", 32'(bus.clock_out[0]), 0);
    bus.ch_enable[0] = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      chk($sformatf("t5_out r=%0d", r), 32'(bus.clock_out[0]), 32'(((r - 1) % 4) < 3));
      chk($sformatf("t5_tick r=%0d", r), 32'(bus.tick[0]), 32'(((r - 1) % 4) == 3));
    end

`ifdef CLKDIV_PHASE_SYNC_EN
    // Test 6: ch0 4/3 and ch1 6/2 phase-aligned by sync_req.
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    chk("t6_sync_out", 32'(bus.clock_out[1:0]), 3);
    chk("t6_sync_tick", 32'(bus.tick[1:0]), 0);
    for (int r = 1; r <= 12; r++) begin
      step();
      chk($sformatf("t6_out0 r=%0d", r), 32'(bus.clock_out[0]), 32'(((r - 1) % 4) < 3));
      chk($sformatf("t6_out1 r=%0d", r), 32'(bus.clock_out[1]), 32'(((r - 1) % 6) < 2));
      chk($sformatf("t6_tick0 r=%0d", r), 32'(bus.tick[0]), 32'((r % 4) == 0));
      chk($sformatf("t6_tick1 r=%0d", r), 32'(bus.tick[1]), 32'((r % 6) == 0));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
